// File: rtl/lsu_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : Load/store unit back end. Accepts one load/store per
//                handshake, checks alignment and funct3, drives the SRAM
//                data port until it answers, then returns sign/zero-extended
//                load data (or store completion / error) on a valid/ready
//                response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 256     // REQ cycles without mem_valid before error; 0 = never
) (
    input  logic        clk,
    input  logic        rst,
    // request channel from execute stage
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // response channel
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // SRAM data port
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [2:0] c_F3_B  = 3'd0;
    localparam logic [2:0] c_F3_H  = 3'd1;
    localparam logic [2:0] c_F3_W  = 3'd2;
    localparam logic [2:0] c_F3_BU = 3'd4;
    localparam logic [2:0] c_F3_HU = 3'd5;

    // Counter only has to reach TIMEOUT-1; it saturates at all-ones.
    localparam int                 c_CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                 c_TO_EN   = (TIMEOUT != 0);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]         r_state;
    logic               r_wen;
    logic [2:0]         r_funct3;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [1:0]         w_state_nxt;
    logic               w_wen_nxt;
    logic [2:0]         w_funct3_nxt;
    logic [31:0]        w_addr_nxt;
    logic [31:0]        w_wdata_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [31:0]        w_rdata_nxt;
    logic               w_err_nxt;

    logic               w_bad;
    logic [1:0]         w_lane;
    logic [31:0]        w_rshift;
    logic [31:0]        w_ext;
    logic [3:0]         w_mask4;
    logic               w_mem_act;
    logic               w_mem_wen;

    assign w_lane    = r_addr[1:0];
    assign w_mem_act = (r_state == c_ST_REQ);
    assign w_mem_wen = w_mem_act & r_wen;

    // Classify the incoming op: misaligned access or reserved funct3.
    always_comb begin
        w_bad = 1'b0;
        if (req_wen) begin
            case (req_funct3)
                c_F3_B:  w_bad = 1'b0;
                c_F3_H:  w_bad = req_addr[0];
                c_F3_W:  w_bad = |req_addr[1:0];
                default: w_bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                c_F3_B, c_F3_BU: w_bad = 1'b0;
                c_F3_H, c_F3_HU: w_bad = req_addr[0];
                c_F3_W:          w_bad = |req_addr[1:0];
                default:         w_bad = 1'b1;
            endcase
        end
    end

    // Extract and extend the addressed byte/half from the SRAM word.
    always_comb begin
        w_rshift = mem_rdata >> {w_lane, 3'b000};
        w_ext    = 32'd0;
        case (r_funct3)
            c_F3_B:  w_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
            c_F3_BU: w_ext = {24'd0, w_rshift[7:0]};
            c_F3_H:  w_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
            c_F3_HU: w_ext = {16'd0, w_rshift[15:0]};
            c_F3_W:  w_ext = mem_rdata;
            default: w_ext = 32'd0;
        endcase
    end

    // Byte-enable pattern for the store width, placed at the addressed lane.
    always_comb begin
        w_mask4 = 4'b0000;
        case (r_funct3)
            c_F3_B:  w_mask4 = 4'b0001 << w_lane;
            c_F3_H:  w_mask4 = 4'b0011 << w_lane;
            c_F3_W:  w_mask4 = 4'b1111;
            default: w_mask4 = 4'b0000;
        endcase
    end

    // Next-state and datapath update for the IDLE -> REQ -> RESP sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_wen_nxt    = r_wen;
        w_funct3_nxt = r_funct3;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_cnt_nxt    = r_cnt;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_wen_nxt    = req_wen;
                    w_funct3_nxt = req_funct3;
                    w_addr_nxt   = req_addr;
                    w_wdata_nxt  = req_wdata;
                    if (w_bad) begin
                        // Rejected ops never touch the SRAM.
                        w_rdata_nxt = 32'd0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_ST_RESP;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_REQ;
                    end
                end
            end
            c_ST_REQ: begin
                if (mem_valid) begin
                    w_rdata_nxt = r_wen ? 32'd0 : w_ext;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = c_ST_RESP;
                end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
                    w_rdata_nxt = 32'd0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State and latched request; async reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_wen    <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_cnt    <= '0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wen    <= w_wen_nxt;
            r_funct3 <= w_funct3_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign req_ready  = (r_state == c_ST_IDLE);
    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // SRAM strobes are pure decodes of registered state, so reset drops them at once.
    assign mem_ren    = w_mem_act & ~r_wen;
    assign mem_wen    = w_mem_wen;
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_wmask  = w_mem_wen ? {4'b0000, w_mask4} : 8'h00;
    assign mem_wdata  = w_mem_wen ? (r_wdata << {w_lane, 3'b000}) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_ctrl
//  Description : Directed table-driven bench for lsu_mem_ctrl with a small
//                SRAM model, plus hand sequences for backpressure, timeout
//                and asynchronous reset mid-operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ren, mem_wen, mem_valid;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_wmask  (mem_wmask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    typedef struct packed {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] word;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_mask;
        logic [31:0] exp_mwdata;
    } vec_t;

    logic [31:0] sram [0:15];
    vec_t        vecs [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(input logic wen, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic pre, input logic [31:0] word,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [7:0] exp_mask, input logic [31:0] exp_mwdata);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.pre = pre; v.word = word; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_mask = exp_mask; v.exp_mwdata = exp_mwdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request at a negedge; DUT accepts at the following posedge.
    task automatic present(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        @(negedge clk);
        chk("req_ready before accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Complete the response handshake and confirm return to IDLE.
    task automatic drain(input string tag);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " resp_valid after drain"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " req_ready after drain"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] wi;
        string      t;
        t  = $sformatf("v%0d", idx);
        wi = v.addr[5:2];
        if (v.pre) sram[wi] = v.word;
        present(v.wen, v.f3, v.addr, v.wdata);
        // now in cycle N+1
        if (v.exp_err) begin
            chk({t, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({t, " resp_err"},   {31'd0, resp_err},   32'd1);
            chk({t, " resp_rdata"}, resp_rdata, 32'd0);
            chk({t, " ren|wen"},    {31'd0, mem_ren | mem_wen}, 32'd0);
        end else begin
            chk({t, " ren N+1"},   {31'd0, mem_ren}, {31'd0, ~v.wen});
            chk({t, " wen N+1"},   {31'd0, mem_wen}, {31'd0, v.wen});
            chk({t, " resp_valid N+1"}, {31'd0, resp_valid}, 32'd0);
            chk({t, " mem_addr"},  mem_addr, {v.addr[31:2], 2'b00});
            chk({t, " mem_wmask"}, {24'd0, mem_wmask}, {24'd0, v.exp_mask});
            chk({t, " mem_wdata"}, mem_wdata, v.exp_mwdata);
            @(negedge clk);   // N+2: SRAM answers
            chk({t, " ren|wen N+2"}, {31'd0, mem_ren | mem_wen}, 32'd1);
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) sram[wi][8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem_valid = 1'b1;
            mem_rdata = sram[wi];
            @(negedge clk);   // N+3: response
            mem_valid = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            chk({t, " resp_valid N+3"}, {31'd0, resp_valid}, 32'd1);
            chk({t, " ren|wen N+3"},    {31'd0, mem_ren | mem_wen}, 32'd0);
            chk({t, " resp_rdata"},     resp_rdata, v.exp_rdata);
            chk({t, " resp_err"},       {31'd0, resp_err}, 32'd0);
        end
        drain(t);
    endtask

    task automatic run_timeout(input string t);
        int ren_cyc;
        ren_cyc = 0;
        present(1'b0, 3'd2, 32'h8000_0010, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) break;
            if (mem_ren) ren_cyc++;
            @(negedge clk);
        end
        chk({t, " resp_valid"},  {31'd0, resp_valid}, 32'd1);
        chk({t, " REQ cycles"},  ren_cyc, TIMEOUT);
        chk({t, " resp_err"},    {31'd0, resp_err}, 32'd1);
        chk({t, " resp_rdata"},  resp_rdata, 32'd0);
        drain(t);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
        for (int i = 0; i < 16; i++) sram[i] = 32'd0;

        //      wen  f3    addr          wdata         pre  word          exp_rdata     err  mask   mwdata
        vecs.push_back(mk(0, 3'd2, 32'h8000_0010, 32'h0,        1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h8000_0013, 32'h0,        1, 32'h80FF_1234, 32'hFFFF_FF80, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd4, 32'h8000_0013, 32'h0,        0, 32'h0,         32'h0000_0080, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd1, 32'h8000_0012, 32'h0,        0, 32'h0,         32'hFFFF_80FF, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd5, 32'h8000_0012, 32'h0,        0, 32'h0,         32'h0000_80FF, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd4, 32'h8000_0010, 32'h0,        0, 32'h0,         32'h0000_0034, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h8000_0011, 32'h0,        0, 32'h0,         32'h0000_0012, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, 3'd0, 32'h8000_0001, 32'h0000_00AB, 1, 32'h1122_3344, 32'h0,        0, 8'h02, 32'h0000_AB00));
        vecs.push_back(mk(0, 3'd2, 32'h8000_0000, 32'h0,        0, 32'h0,         32'h1122_AB44, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, 3'd2, 32'h8000_0008, 32'hCAFE_F00D, 1, 32'h0,         32'h0,         0, 8'h0F, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 3'd1, 32'h8000_0008, 32'h0,        0, 32'h0,         32'hFFFF_F00D, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd5, 32'h8000_000A, 32'h0,        0, 32'h0,         32'h0000_CAFE, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h8000_0009, 32'h0,        0, 32'h0,         32'hFFFF_FFF0, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, 3'd1, 32'h8000_0006, 32'h0000_BEEF, 1, 32'h0,         32'h0,         0, 8'h0C, 32'hBEEF_0000));
        vecs.push_back(mk(1, 3'd0, 32'h8000_0007, 32'hFFFF_FF11, 0, 32'h0,         32'h0,         0, 8'h08, 32'h1100_0000));
        vecs.push_back(mk(0, 3'd2, 32'h8000_0004, 32'h0,        0, 32'h0,         32'h11EF_0000, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd2, 32'h8000_0002, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(1, 3'd1, 32'h8000_0003, 32'h0000_1234, 0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd1, 32'h8000_0001, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd5, 32'h8000_0005, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd3, 32'h8000_0000, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd6, 32'h8000_0000, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(0, 3'd7, 32'h8000_0000, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(1, 3'd4, 32'h8000_0000, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));
        vecs.push_back(mk(1, 3'd2, 32'h8000_0001, 32'h0,        0, 32'h0,         32'h0,         1, 8'h00, 32'h0));

        // Reset state
        @(negedge clk);
        chk("rst req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst mem_ren|wen", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("rst mem_wmask",  {24'd0, mem_wmask}, 32'd0);
        chk("rst mem_addr",   mem_addr, 32'd0);
        chk("rst mem_wdata",  mem_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Backpressure: response held for 5 cycles, new request ignored meanwhile
        sram[3] = 32'h55AA_00FF;
        present(1'b0, 3'd2, 32'h8000_000C, 32'd0);
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = sram[3];
        @(negedge clk);
        mem_valid = 1'b0; mem_rdata = 32'd0;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0010;
        for (int i = 0; i < 5; i++) begin
            chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp resp_rdata", resp_rdata, 32'h55AA_00FF);
            chk("bp req_ready",  {31'd0, req_ready}, 32'd0);
            chk("bp mem_ren",    {31'd0, mem_ren}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain("bp");
        @(negedge clk);
        chk("bp no spurious op", {31'd0, mem_ren | resp_valid}, 32'd0);

        // Timeout, twice to show the counter restarts on each REQ entry
        run_timeout("to1");
        run_timeout("to2");

        // mem_valid on the last REQ cycle wins over the timeout
        present(1'b0, 3'd2, 32'h8000_0010, 32'd0);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("late mem_ren", {31'd0, mem_ren}, 32'd1);
        mem_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_valid = 1'b0; mem_rdata = 32'd0;
        chk("late resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("late resp_err",   {31'd0, resp_err}, 32'd0);
        chk("late resp_rdata", resp_rdata, 32'h0BAD_F00D);
        drain("late");

        // Asynchronous reset during REQ
        present(1'b0, 3'd2, 32'h8000_0010, 32'd0);
        chk("arst mem_ren before", {31'd0, mem_ren}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst mem_ren",    {31'd0, mem_ren}, 32'd0);
        chk("arst req_ready",  {31'd0, req_ready}, 32'd1);
        chk("arst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst mem_addr",   mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;   // stray valid in IDLE
        @(negedge clk);
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("arst no resp", {31'd0, resp_valid}, 32'd0);
            chk("arst idle",    {31'd0, req_ready}, 32'd1);
            @(negedge clk);
        end

        // Recovery after reset
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
